// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle MIPS-style multiply/divide unit with HI/LO regs.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int         c_CNT_W   = 7;
    localparam logic       c_IDLE    = 1'b0;
    localparam logic       c_RUN     = 1'b1;
    localparam logic [2:0] c_OP_DIV  = 3'b010;
    localparam logic [2:0] c_OP_DIVU = 3'b011;
    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    logic               r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_is_div;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Even opcodes of both classes are the signed variants.
    assign w_signed = ~r_op[0];
    assign w_is_div = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);

    // Sign/zero-extend to 2*WIDTH so one unsigned multiplier serves both forms.
    assign w_a_ext   = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext   = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = r_op[2] ? ({r_hi, r_lo} + w_prod) : w_prod;

    // Signed division on magnitudes; MIN_INT / -1 falls out as MIN_INT rem 0.
    assign w_a_neg = w_signed & r_a[WIDTH-1];
    assign w_b_neg = w_signed & r_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= c_IDLE;
                r_count <= '0;
            end else if (r_state == c_IDLE) begin
                if (start) begin
                    case (op)
                        c_OP_MTHI: r_hi <= A;
                        c_OP_MTLO: r_lo <= A;
                        c_OP_DIV, c_OP_DIVU: begin
                            r_state <= c_RUN;
                            r_count <= c_CNT_W'(DIV_CYCLES);
                            r_op    <= op;
                            r_a     <= A;
                            r_b     <= B;
                        end
                        default: begin
                            r_state <= c_RUN;
                            r_count <= c_CNT_W'(MUL_CYCLES);
                            r_op    <= op;
                            r_a     <= A;
                            r_b     <= B;
                        end
                    endcase
                end
            end else begin
                r_count <= r_count - 1'b1;
                if (r_count == c_CNT_W'(1)) begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b1;
                    if (!w_is_div) begin
                        {r_hi, r_lo} <= w_mul_res;
                    end else if (r_b != '0) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state == c_RUN);
    assign done = r_done;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width; legal values are 8 to 64.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 5, meaning busy cycles for multiply-class ops; legal values are 1 to 16.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for divide-class ops; legal values are 1 to 64.
REQ-004 The block SHALL have a single clock `clk` and a synchronous, active-high reset `reset`.
REQ-005 Ports SHALL be:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  launch request, sampled on rising edge
- op  input  3  operation code
- flush  input  1  abort the in-flight operation
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt)
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse on commit

Function
REQ-006 Op encoding SHALL be: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd (signed), 111 maddu.
REQ-007 The FSM SHALL have two states, IDLE and RUN; busy SHALL equal (state==RUN).
REQ-008 In IDLE with start=1 and op in {mult, multu, madd, maddu}, the block SHALL enter RUN with a cycle counter of MUL_CYCLES.
- A and B are latched at that edge.
- HI and LO are latched at that edge, as the accumulator for madd/maddu.
REQ-009 In IDLE with start=1 and op in {div, divu}, the block SHALL enter RUN with a counter of DIV_CYCLES and latch A and B.
REQ-010 In IDLE with start=1 and op=mthi (resp. mtlo), the block SHALL write A into HI (resp. LO) at that edge.
- busy stays 0.
- done is not pulsed.
REQ-011 In RUN the counter SHALL decrement each edge; on the edge where the counter equals 1, the block SHALL:
- write HI and LO,
- return to IDLE,
- set done=1 for exactly the following cycle.
REQ-012 Total latency SHALL be N cycles of busy (N = MUL_CYCLES or DIV_CYCLES), with results visible on HI/LO in the first cycle after busy falls.
REQ-013 mult/multu SHALL compute the 2*WIDTH-bit signed/unsigned product; {HI,LO} = product.
REQ-014 madd/maddu SHALL compute {HI,LO} = {HI,LO}_latched + product (signed/unsigned), wrapping modulo 2^(2*WIDTH).
REQ-015 div/divu SHALL write LO = quotient and HI = remainder.
- Signed quotient truncates toward zero.
- Signed remainder takes the sign of the dividend.
REQ-016 Signed div of MIN_INT by -1 SHALL yield LO = MIN_INT and HI = 0.
REQ-017 Division by zero SHALL run the full DIV_CYCLES, assert done, and leave HI and LO unchanged.
REQ-018 start asserted while busy=1 SHALL be ignored, including mthi/mtlo.
REQ-019 Operand changes on A/B during RUN SHALL NOT affect the result.
REQ-020 flush=1 on any edge SHALL force IDLE without writing HI/LO and without a done pulse.
- flush overrides start in the same cycle; mthi/mtlo are also suppressed.
REQ-021 start and commit in the same cycle SHALL be impossible, because start is ignored while busy; a start on the cycle immediately after busy falls SHALL be accepted.
REQ-022 HI, LO, busy and done SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-023 On reset=1 at a rising edge, the block SHALL go to IDLE and clear HI, LO, the counter, the operand latches and done to 0.
REQ-024 Reset SHALL take priority over flush and start, and SHALL abort an in-flight operation with no commit.

Verification
REQ-025 WIDTH=32, mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses once.
REQ-026 multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE; then maddu A=1, B=1 -> HI=0x00000001, LO=0xFFFFFFFF.
REQ-027 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> HI/LO unchanged, done pulses.
REQ-028 mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle, busy=0; mtlo issued while busy -> ignored, LO unchanged.
REQ-029 Start mult, assert flush on the 3rd busy cycle -> busy=0 next cycle, HI/LO retain prior values, no done; a start on the following cycle is accepted.
REQ-030 WIDTH=8, MUL_CYCLES=1: mult A=0x80, B=0x80 -> one busy cycle, HI=0x40, LO=0x00; reset mid-div -> all outputs 0.
